// File: rtl/axis_pkt_demux_if.sv
// AXI-Stream beat bundle (data, valid, ready, last) shared by the demux ports.
// No logic of its own; the latency is whatever the attached modules add.
// tready runs slave -> master, and every other signal runs master -> slave.
interface axis_pkt_demux_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  // Source side: drives the beat, observes ready.
  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  // Sink side: observes the beat, drives ready.
  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_pkt_demux.sv
// Whole-packet demux: the header beat's DEST_BIT picks port A or B, and the route is held until tlast.
// Latency: 1 cycle from input acceptance to output valid, with a full 1 beat/cycle per port.
// Backpressure: input ready follows only the routed port's register (empty or draining); the other port drains freely.
module axis_pkt_demux #(
  parameter int DATA_W   = 32,
  parameter int DEST_BIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic                 axis_aclk,
  input  logic                 axis_aresetn,
  axis_pkt_demux_if.slave      s0k_axis,
  axis_pkt_demux_if.master     m0a_axis,
  axis_pkt_demux_if.master     m0b_axis,
  output logic [CNT_W-1:0]     pkt_cnt_a,
  output logic [CNT_W-1:0]     pkt_cnt_b
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTE_A = 2'd1,
    ROUTE_B = 2'd2
  } state_e;

  state_e              state_q, state_d;

  logic                a_vld_q, a_vld_d;
  logic                a_last_q, a_last_d;
  logic [DATA_W-1:0]   a_dat_q, a_dat_d;

  logic                b_vld_q, b_vld_d;
  logic                b_last_q, b_last_d;
  logic [DATA_W-1:0]   b_dat_q, b_dat_d;

  logic [CNT_W-1:0]    cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]    cnt_b_q, cnt_b_d;

  logic                ld_ok_a;
  logic                ld_ok_b;
  logic                sel;
  logic                route_b;
  logic                in_rdy;
  logic                in_xfer;
  logic                ld_a;
  logic                ld_b;

  // Route decode: a register can take a beat when it is empty or draining this cycle.
  // In IDLE the beat on the bus is a header, so its own DEST_BIT picks the port.
  always_comb begin
    ld_ok_a = ~a_vld_q | m0a_axis.tready;
    ld_ok_b = ~b_vld_q | m0b_axis.tready;
    sel     = s0k_axis.tdata[DEST_BIT];
    route_b = sel;
    unique case (state_q)
      IDLE:    route_b = sel;
      ROUTE_A: route_b = 1'b0;
      ROUTE_B: route_b = 1'b1;
      default: route_b = sel;
    endcase
    in_rdy  = route_b ? ld_ok_b : ld_ok_a;
    in_xfer = s0k_axis.tvalid & in_rdy;
    ld_a    = in_xfer & ~route_b;
    ld_b    = in_xfer &  route_b;
  end

  // Packet-lock FSM: a non-last beat locks the chosen route, and any last beat frees it.
  always_comb begin
    state_d = state_q;
    if (in_xfer) begin
      if (s0k_axis.tlast) begin
        state_d = IDLE;
      end else begin
        state_d = route_b ? ROUTE_B : ROUTE_A;
      end
    end
  end

  // Output register next-state: load on accept, clear valid once drained, otherwise hold.
  always_comb begin
    a_vld_d  = ld_a | (a_vld_q & ~m0a_axis.tready);
    a_last_d = ld_a ? s0k_axis.tlast : a_last_q;
    a_dat_d  = ld_a ? s0k_axis.tdata : a_dat_q;

    b_vld_d  = ld_b | (b_vld_q & ~m0b_axis.tready);
    b_last_d = ld_b ? s0k_axis.tlast : b_last_q;
    b_dat_d  = ld_b ? s0k_axis.tdata : b_dat_q;
  end

  // Packet counters: bump when a last beat enters a port register, and wrap naturally.
  always_comb begin
    cnt_a_d = cnt_a_q + {{(CNT_W-1){1'b0}}, (ld_a & s0k_axis.tlast)};
    cnt_b_d = cnt_b_q + {{(CNT_W-1){1'b0}}, (ld_b & s0k_axis.tlast)};
  end

  // Control state, output valid/last and counters. Reset drops any partial packet.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q  <= IDLE;
      a_vld_q  <= 1'b0;
      a_last_q <= 1'b0;
      b_vld_q  <= 1'b0;
      b_last_q <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_vld_q  <= a_vld_d;
      a_last_q <= a_last_d;
      b_vld_q  <= b_vld_d;
      b_last_q <= b_last_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
    end
  end

  // Datapath registers carry no reset; their contents only matter while valid is high.
  always_ff @(posedge axis_aclk) begin
    a_dat_q <= a_dat_d;
    b_dat_q <= b_dat_d;
  end

  assign s0k_axis.tready = in_rdy;

  assign m0a_axis.tvalid = a_vld_q;
  assign m0a_axis.tdata  = a_dat_q;
  assign m0a_axis.tlast  = a_last_q;

  assign m0b_axis.tvalid = b_vld_q;
  assign m0b_axis.tdata  = b_dat_q;
  assign m0b_axis.tlast  = b_last_q;

  assign pkt_cnt_a = cnt_a_q;
  assign pkt_cnt_b = cnt_b_q;

endmodule

// File: tb/tb_axis_pkt_demux.sv
module tb_axis_pkt_demux;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_pkt_demux_if #(.DATA_W(DW)) s_if ();
  axis_pkt_demux_if #(.DATA_W(DW)) a_if ();
  axis_pkt_demux_if #(.DATA_W(DW)) b_if ();
  logic [CW-1:0] cnt_a, cnt_b;

  axis_pkt_demux #(.DATA_W(DW), .DEST_BIT(0), .CNT_W(CW)) dut (
    .axis_aclk   (clk),
    .axis_aresetn(rst_n),
    .s0k_axis    (s_if),
    .m0a_axis    (a_if),
    .m0b_axis    (b_if),
    .pkt_cnt_a   (cnt_a),
    .pkt_cnt_b   (cnt_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: packets are routed by their first beat's bit 0 until a last beat.
  logic [32:0] exp_a[$], exp_b[$], obs_a[$], obs_b[$];
  bit in_pkt = 0;
  bit cur_port = 0;
  int mcnt_a = 0, mcnt_b = 0;
  int stall_cnt = 0;
  int mode_a = 1, mode_b = 1;   // 0 = ready low, 1 = ready high, 2 = random

  // Monitor: sampled on the falling edge, while everything is stable for the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_a.delete(); exp_b.delete(); obs_a.delete(); obs_b.delete();
      in_pkt = 0; mcnt_a = 0; mcnt_b = 0;
    end else begin
      if (s_if.tvalid && s_if.tready) begin
        if (!in_pkt) cur_port = s_if.tdata[0];
        if (cur_port) exp_b.push_back({s_if.tlast, s_if.tdata});
        else          exp_a.push_back({s_if.tlast, s_if.tdata});
        if (s_if.tlast) begin
          in_pkt = 0;
          if (cur_port) mcnt_b++; else mcnt_a++;
        end else begin
          in_pkt = 1;
        end
      end
      if (s_if.tvalid && !s_if.tready) stall_cnt++;
      if (a_if.tvalid && a_if.tready) obs_a.push_back({a_if.tlast, a_if.tdata});
      if (b_if.tvalid && b_if.tready) obs_b.push_back({b_if.tlast, b_if.tdata});
    end
  end

  // Downstream ready drivers.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      a_if.tready = (mode_a == 2) ? 1'($urandom_range(0, 1)) : (mode_a != 0);
      b_if.tready = (mode_b == 2) ? 1'($urandom_range(0, 1)) : (mode_b != 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at 5 ms, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [31:0] d, input logic l);
    int budget = 200;
    bit acc = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tlast  = l;
    while (!acc && budget > 0) begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      #1;
      budget--;
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: beat %h not accepted, tready=%b, required 1 within 200 cycles", d, s_if.tready);
    end
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain();
    int budget = 100;
    mode_a = 1; mode_b = 1;
    @(posedge clk); #1;
    while ((a_if.tvalid || b_if.tvalid) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (a_if.tvalid || b_if.tvalid) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: tvalid a=%b b=%b, required both 0", a_if.tvalid, b_if.tvalid);
    end
  endtask

  task automatic clear_q();
    exp_a.delete(); exp_b.delete(); obs_a.delete(); obs_b.delete();
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (a_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_a_vld: got %b required 0", a_if.tvalid); end
    n_cmp++; if (b_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_b_vld: got %b required 0", b_if.tvalid); end
    n_cmp++; if (a_if.tlast !== 1'b0) begin n_bad++; $display("FAIL rst_a_last: got %b required 0", a_if.tlast); end
    n_cmp++; if (b_if.tlast !== 1'b0) begin n_bad++; $display("FAIL rst_b_last: got %b required 0", b_if.tlast); end
    n_cmp++; if (cnt_a !== 16'h0) begin n_bad++; $display("FAIL rst_cnt_a: got %h required 0000", cnt_a); end
    n_cmp++; if (cnt_b !== 16'h0) begin n_bad++; $display("FAIL rst_cnt_b: got %h required 0000", cnt_b); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_three_beat_a();
    logic [32:0] want[$];
    bit ok;
    clear_q();
    send_beat(32'h0, 1'b0);
    n_cmp++;
    if (a_if.tvalid !== 1'b1 || a_if.tdata !== 32'h0) begin
      n_bad++; $display("FAIL t1_latency: a vld=%b data=%h, required vld=1 data=00000000 one cycle after accept", a_if.tvalid, a_if.tdata);
    end
    send_beat(32'hA, 1'b0);
    send_beat(32'hC, 1'b1);
    idle();
    drain();
    want = '{33'h0_00000000, 33'h0_0000000A, 33'h1_0000000C};
    ok = (obs_a.size() == 3);
    for (int i = 0; i < 3; i++) if (ok && obs_a[i] !== want[i]) ok = 0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL t1_port_a: got %0d beats, required 0,A,C(last)", obs_a.size()); end
    n_cmp++; if (obs_b.size() != 0) begin n_bad++; $display("FAIL t1_port_b: got %0d beats required 0", obs_b.size()); end
    n_cmp++; if (cnt_a !== 16'd1) begin n_bad++; $display("FAIL t1_cnt_a: got %0d required 1", cnt_a); end
  endtask

  task automatic test_single_beat_b();
    clear_q();
    send_beat(32'h1, 1'b1);
    send_beat(32'h0, 1'b1);   // an IDLE FSM must route this header to A
    idle();
    drain();
    n_cmp++; if (obs_b.size() != 1 || obs_b[0] !== 33'h1_00000001) begin n_bad++; $display("FAIL t2_port_b: got %0d beats, required one beat 00000001 with last", obs_b.size()); end
    n_cmp++; if (cnt_b !== 16'd1) begin n_bad++; $display("FAIL t2_cnt_b: got %0d required 1", cnt_b); end
    n_cmp++; if (obs_a.size() != 1 || obs_a[0] !== 33'h1_00000000) begin n_bad++; $display("FAIL t2_idle_after: got %0d A beats, required one beat 00000000 with last", obs_a.size()); end
    n_cmp++; if (cnt_a !== 16'(mcnt_a)) begin n_bad++; $display("FAIL t2_cnt_a: got %0d required %0d", cnt_a, 16'(mcnt_a)); end
  endtask

  task automatic test_backpressure();
    logic [32:0] want[$];
    bit ok;
    bit done3 = 0;
    int budget = 100;
    clear_q();
    mode_b = 0;
    @(posedge clk); #2;
    fork
      begin
        send_beat(32'h3, 1'b0);
        send_beat(32'h11, 1'b0);
        send_beat(32'h22, 1'b0);
        send_beat(32'h33, 1'b1);
        idle();
        done3 = 1;
      end
    join_none
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (b_if.tvalid !== 1'b1) begin n_bad++; $display("FAIL t3_b_vld[%0d]: got %b required 1", i, b_if.tvalid); end
      n_cmp++; if (b_if.tdata !== 32'h3) begin n_bad++; $display("FAIL t3_b_stable[%0d]: got %h required 00000003", i, b_if.tdata); end
      n_cmp++; if (s_if.tready !== 1'b0) begin n_bad++; $display("FAIL t3_s_rdy[%0d]: got %b required 0", i, s_if.tready); end
    end
    mode_b = 1;
    while (!done3 && budget > 0) begin @(posedge clk); #2; budget--; end
    n_cmp++; if (!done3) begin n_bad++; $display("FAIL t3_release: packet done=%b, required 1 after ready release", done3); end
    drain();
    want = '{33'h0_00000003, 33'h0_00000011, 33'h0_00000022, 33'h1_00000033};
    ok = (obs_b.size() == 4);
    for (int i = 0; i < 4; i++) if (ok && obs_b[i] !== want[i]) ok = 0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL t3_port_b: got %0d beats, required 3,11,22,33(last) exactly once", obs_b.size()); end
    n_cmp++; if (cnt_b !== 16'(mcnt_b)) begin n_bad++; $display("FAIL t3_cnt_b: got %0d required %0d", cnt_b, 16'(mcnt_b)); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_q();
    stall_cnt = 0;
    send_beat(32'h10, 1'b0); send_beat(32'h21, 1'b0); send_beat(32'h30, 1'b1);
    send_beat(32'h41, 1'b0); send_beat(32'h50, 1'b0); send_beat(32'h60, 1'b1);
    send_beat(32'h70, 1'b0); send_beat(32'h81, 1'b0); send_beat(32'h93, 1'b1);
    idle();
    drain();
    n_cmp++; if (stall_cnt != 0) begin n_bad++; $display("FAIL t4_bubbles: got %0d stall cycles required 0", stall_cnt); end
    n_cmp++; if (obs_a.size() != 6 || obs_b.size() != 3) begin n_bad++; $display("FAIL t4_split: got a=%0d b=%0d beats required a=6 b=3", obs_a.size(), obs_b.size()); end
    n_cmp++; if (obs_a.size() < 2 || obs_a[1] !== 33'h0_00000021) begin n_bad++; $display("FAIL t4_locked_route: body beat 21 (bit0=1) not second on A, required it there"); end
    ok = (obs_a.size() == exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) if (ok && obs_a[i] !== exp_a[i]) ok = 0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL t4_order_a: got %0d beats, required %0d in model order", obs_a.size(), exp_a.size()); end
    ok = (obs_b.size() == exp_b.size());
    for (int i = 0; i < exp_b.size(); i++) if (ok && obs_b[i] !== exp_b[i]) ok = 0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL t4_order_b: got %0d beats, required %0d in model order", obs_b.size(), exp_b.size()); end
  endtask

  task automatic test_random();
    bit ok;
    clear_q();
    mode_a = 2; mode_b = 2;
    for (int p = 0; p < 40; p++) begin
      int len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        send_beat($urandom, (k == len - 1));
        if ($urandom_range(0, 3) == 0) begin idle(); @(posedge clk); #1; end
      end
    end
    idle();
    drain();
    ok = (obs_a.size() == exp_a.size());
    for (int i = 0; i < exp_a.size(); i++) if (ok && obs_a[i] !== exp_a[i]) ok = 0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd_port_a: got %0d beats, required %0d matching model", obs_a.size(), exp_a.size()); end
    ok = (obs_b.size() == exp_b.size());
    for (int i = 0; i < exp_b.size(); i++) if (ok && obs_b[i] !== exp_b[i]) ok = 0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd_port_b: got %0d beats, required %0d matching model", obs_b.size(), exp_b.size()); end
    n_cmp++; if (cnt_a !== 16'(mcnt_a)) begin n_bad++; $display("FAIL rnd_cnt_a: got %0d required %0d", cnt_a, 16'(mcnt_a)); end
    n_cmp++; if (cnt_b !== 16'(mcnt_b)) begin n_bad++; $display("FAIL rnd_cnt_b: got %0d required %0d", cnt_b, 16'(mcnt_b)); end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 65535; i++) send_beat(32'h0, 1'b1);
    idle();
    drain();
    n_cmp++; if (cnt_a !== 16'hFFFF) begin n_bad++; $display("FAIL t5_preload: got %h required ffff", cnt_a); end
    send_beat(32'h0, 1'b1);
    idle();
    drain();
    n_cmp++; if (cnt_a !== 16'h0000) begin n_bad++; $display("FAIL t5_wrap: got %h required 0000", cnt_a); end
    n_cmp++; if (cnt_b !== 16'h0000) begin n_bad++; $display("FAIL t5_cnt_b: got %h required 0000", cnt_b); end
    clear_q();
  endtask

  task automatic test_reset_mid_packet();
    send_beat(32'h1, 1'b1);      // make cnt_b non-zero before the reset
    send_beat(32'h10, 1'b0);
    send_beat(32'h20, 1'b0);
    idle();
    #1;
    n_cmp++; if (a_if.tvalid !== 1'b1 || cnt_b !== 16'd1) begin n_bad++; $display("FAIL t6_pre: a vld=%b cnt_b=%0d required vld=1 cnt_b=1", a_if.tvalid, cnt_b); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_if.tvalid !== 1'b0 || b_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL t6_vld: a=%b b=%b required 0,0", a_if.tvalid, b_if.tvalid); end
    n_cmp++; if (cnt_a !== 16'h0 || cnt_b !== 16'h0) begin n_bad++; $display("FAIL t6_cnt: a=%0d b=%0d required 0,0", cnt_a, cnt_b); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    send_beat(32'h5, 1'b0);
    send_beat(32'h8, 1'b1);
    idle();
    drain();
    n_cmp++; if (obs_b.size() != 2 || obs_b[0] !== 33'h0_00000005 || obs_b[1] !== 33'h1_00000008) begin n_bad++; $display("FAIL t6_new_hdr: got %0d B beats, required 5,8(last)", obs_b.size()); end
    n_cmp++; if (obs_a.size() != 0) begin n_bad++; $display("FAIL t6_no_a: got %0d A beats required 0", obs_a.size()); end
    n_cmp++; if (cnt_b !== 16'd1 || cnt_a !== 16'd0) begin n_bad++; $display("FAIL t6_cnt_after: a=%0d b=%0d required 0,1", cnt_a, cnt_b); end
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tlast  = 1'b0;
    a_if.tready = 1'b1;
    b_if.tready = 1'b1;
    test_reset();
    test_three_beat_a();
    test_single_beat_b();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_wrap();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
